// File: rtl/pixie_dma_fetch.sv
// pixie_dma_fetch: CDP1802-style DMA-out burst fetcher feeding the Pixie video generator.
module pixie_dma_fetch #(
  parameter logic [15:0] BASE_ADDR      = 16'h0900,
  parameter int          BYTES_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        dmao_n,
  input  logic        int_frame,
  input  logic        r0_wr,
  input  logic [15:0] r0_din,
  input  logic [7:0]  mem_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [1:0]  SC,
  output logic        cpu_hold,
  output logic [7:0]  dma_data,
  output logic        dma_valid,
  output logic [15:0] r0
);
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;
  localparam logic [7:0] LAST = 8'(BYTES_PER_LINE - 1);
  state_t      r_state, w_next;
  logic [15:0] r_r0, r_mem_addr, r_wr_val, w_wr_val, w_r0_upd, w_r0_inc;
  logic [7:0]  r_cnt, r_dma_data;
  logic        r_busy, r_dma_valid, r_int_d, r_wr_pend, r_rl_pend;
  logic        w_wr_pend, w_rl_pend, w_last;
  always_comb begin
    w_wr_pend = r_wr_pend | r0_wr;
    w_wr_val  = r0_wr ? r0_din : r_wr_val;
    w_rl_pend = r_rl_pend | (int_frame & ~r_int_d);
    w_r0_upd  = w_wr_pend ? w_wr_val : w_rl_pend ? BASE_ADDR : r_r0;
    w_r0_inc  = r_r0 + 16'd1;
    w_last    = r_cnt == LAST;
    w_next    = !clk_enable       ? r_state :
                r_state == IDLE   ? (dmao_n ? IDLE : FETCH) :
                r_state == FETCH  ? CAPTURE :
                w_last            ? IDLE : FETCH;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // Pending R0 updates are folded in only while idle so a burst never sees R0 jump.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_r0        <= BASE_ADDR;
      r_mem_addr  <= BASE_ADDR;
      r_wr_val    <= '0;
      r_cnt       <= '0;
      r_dma_data  <= '0;
      r_busy      <= 1'b0;
      r_dma_valid <= 1'b0;
      r_int_d     <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_rl_pend   <= 1'b0;
    end else begin
      r_dma_valid <= 1'b0;
      if (clk_enable) begin
        r_int_d  <= int_frame;
        r_wr_val <= w_wr_val;
        if (r_state == IDLE) begin
          r_r0      <= w_r0_upd;
          r_wr_pend <= 1'b0;
          r_rl_pend <= 1'b0;
          if (!dmao_n) begin
            r_mem_addr <= w_r0_upd;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
          end
        end else begin
          r_wr_pend <= w_wr_pend;
          r_rl_pend <= w_rl_pend;
          if (r_state == CAPTURE) begin
            r_dma_data  <= mem_data;
            r_dma_valid <= 1'b1;
            r_r0        <= w_r0_inc;
            r_cnt       <= r_cnt + 8'd1;
            if (w_last) r_busy <= 1'b0;
            else        r_mem_addr <= w_r0_inc;
          end
        end
      end
    end
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_busy;
  assign SC        = {r_busy, 1'b0};
  assign cpu_hold  = r_busy;
  assign dma_data  = r_dma_data;
  assign dma_valid = r_dma_valid;
  assign r0        = r_r0;
endmodule

// File: tb/tb_pixie_dma_fetch.sv
// tb_pixie_dma_fetch: scenario tasks plus randomized traffic against a burst-level reference model.
module tb_pixie_dma_fetch;
  localparam logic [15:0] BASE = 16'h0900;
  localparam int BPL = 8;
  logic clk = 1'b0, reset = 1'b1, clk_enable = 1'b0, dmao_n = 1'b1, int_frame = 1'b0, r0_wr = 1'b0;
  logic [15:0] r0_din = '0;
  logic [7:0] mem_data;
  logic [15:0] mem_addr, r0;
  logic mem_rd, cpu_hold, dma_valid;
  logic [1:0] SC;
  logic [7:0] dma_data;
  int checks = 0, errors = 0;
  int m_left;
  logic [15:0] m_ptr, m_wr_val;
  logic m_wr_pend, m_rl_pend, m_int_prev, e_valid, e_busy;
  logic [7:0] e_data;

  pixie_dma_fetch #(.BASE_ADDR(BASE), .BYTES_PER_LINE(BPL)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .dmao_n(dmao_n), .int_frame(int_frame),
    .r0_wr(r0_wr), .r0_din(r0_din), .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .SC(SC), .cpu_hold(cpu_hold), .dma_data(dma_data), .dma_valid(dma_valid), .r0(r0));

  always #5 clk = ~clk;
  assign mem_data = mem_addr[7:0] ^ mem_addr[15:8];

  function automatic logic [7:0] mem_of(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic model_reset();
    m_left = 0; m_ptr = BASE; m_wr_val = '0; m_wr_pend = 0; m_rl_pend = 0; m_int_prev = 0;
    e_valid = 0; e_data = '0; e_busy = 0;
  endtask

  // A burst is 2*BPL ticks; every tick with an odd number of ticks remaining delivers a byte.
  task automatic model_tick(input logic dn, input logic it, input logic wr, input logic [15:0] din);
    if (it && !m_int_prev) m_rl_pend = 1;
    m_int_prev = it;
    if (wr) begin m_wr_pend = 1; m_wr_val = din; end
    if (m_left == 0) begin
      if (m_wr_pend) m_ptr = m_wr_val;
      else if (m_rl_pend) m_ptr = BASE;
      m_wr_pend = 0; m_rl_pend = 0;
      if (!dn) m_left = 2 * BPL;
    end else begin
      if (m_left % 2 == 1) begin
        e_valid = 1; e_data = mem_of(m_ptr); m_ptr = m_ptr + 16'd1;
      end
      m_left--;
    end
  endtask

  task automatic step(input logic en, input logic dn, input logic it, input logic wr, input logic [15:0] din);
    clk_enable = en; dmao_n = dn; int_frame = it; r0_wr = wr; r0_din = din;
    @(posedge clk);
    e_valid = 0;
    if (en) model_tick(dn, it, wr, din);
    e_busy = m_left > 0;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({SC, cpu_hold, mem_rd, mem_addr, dma_data, dma_valid, r0} !== {2'b00, 1'b0, 1'b0, BASE, 8'h00, 1'b0, BASE}) begin
      errors++; $display("FAIL reset_initial: got sc=%b h=%b rd=%b a=%h d=%h v=%b r0=%h", SC, cpu_hold, mem_rd, mem_addr, dma_data, dma_valid, r0);
    end
    reset = 0; model_reset();
    for (int i = 0; i < 5; i++) step(1, i != 0, 0, 0, '0);
    #3 reset = 1;
    #1;
    checks++;
    if ({SC, cpu_hold, mem_rd, mem_addr, dma_data, dma_valid, r0} !== {2'b00, 1'b0, 1'b0, BASE, 8'h00, 1'b0, BASE}) begin
      errors++; $display("FAIL reset_async: got sc=%b h=%b rd=%b a=%h d=%h v=%b r0=%h", SC, cpu_hold, mem_rd, mem_addr, dma_data, dma_valid, r0);
    end
    @(posedge clk); #1 reset = 0; model_reset();
  endtask

  task automatic test_single_burst();
    int n = 0, busy_clks = 0, last = 0;
    for (int c = 0; c < 24; c++) begin
      step(1, c != 0, 0, 0, '0);
      if (SC == 2'b10) busy_clks++;
      checks++;
      if ({dma_valid, dma_data, SC, cpu_hold, mem_rd, r0} !== {e_valid, e_data, (e_busy ? 2'b10 : 2'b00), e_busy, e_busy, m_ptr}) begin
        errors++; $display("FAIL single clk %0d: got v=%b d=%h sc=%b r0=%h exp v=%b d=%h busy=%b r0=%h", c, dma_valid, dma_data, SC, r0, e_valid, e_data, e_busy, m_ptr);
      end
      if (dma_valid) begin
        checks++;
        if (dma_data !== 8'(n ^ 9) || (n > 0 && c - last != 2)) begin
          errors++; $display("FAIL single_byte %0d: got d=%h gap=%0d exp d=%h gap=2", n, dma_data, c - last, 8'(n ^ 9));
        end
        n++; last = c;
      end
    end
    checks++;
    if (n != BPL || busy_clks != 2 * BPL || r0 !== BASE + 16'd8) begin
      errors++; $display("FAIL single_summary: got strobes=%0d busy=%0d r0=%h exp 8 16 0908", n, busy_clks, r0);
    end
  endtask

  task automatic test_deferred_reload();
    int n = 0;
    step(1, 1, 0, 1, BASE);
    for (int c = 0; c < 17; c++) begin
      step(1, c != 0, n >= 2, 0, '0);
      checks++;
      if ({dma_valid, dma_data, SC, r0} !== {e_valid, e_data, (e_busy ? 2'b10 : 2'b00), m_ptr}) begin
        errors++; $display("FAIL deferred clk %0d: got v=%b d=%h sc=%b r0=%h exp v=%b d=%h r0=%h", c, dma_valid, dma_data, SC, r0, e_valid, e_data, m_ptr);
      end
      if (dma_valid) n++;
    end
    checks++;
    if (n != BPL || SC !== 2'b00 || r0 !== BASE + 16'd8) begin
      errors++; $display("FAIL deferred_end: got strobes=%0d sc=%b r0=%h exp 8 00 0908", n, SC, r0);
    end
    step(1, 1, 1, 0, '0);
    checks++;
    if (r0 !== BASE) begin errors++; $display("FAIL deferred_reload: got r0=%h exp %h", r0, BASE); end
    step(1, 1, 0, 0, '0);
  endtask

  task automatic test_write_priority();
    logic [7:0] exp_d [8] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int n = 0;
    step(1, 1, 0, 0, '0);
    step(1, 1, 1, 1, 16'hFFFE);
    for (int c = 0; c < 20; c++) begin
      step(1, c != 0, 1, 0, '0);
      if (dma_valid) begin
        checks++;
        if (n >= 8 || dma_data !== exp_d[n]) begin
          errors++; $display("FAIL wrap_byte %0d: got d=%h exp %h", n, dma_data, n < 8 ? exp_d[n] : 8'hxx);
        end
        n++;
      end
    end
    checks++;
    if (n != BPL || r0 !== 16'h0006) begin
      errors++; $display("FAIL wrap_end: got strobes=%0d r0=%h exp 8 0006", n, r0);
    end
    step(1, 1, 0, 0, '0);
  endtask

  task automatic test_back_to_back();
    int n = 0, gaps = 0, c = 0;
    logic [15:0] start = r0;
    for (c = 0; c < 40; c++) begin
      step(1, 0, 0, 0, '0);
      if (SC == 2'b00) gaps++;
      if (dma_valid) n++;
    end
    for (c = 0; c < 40 && SC == 2'b10; c++) begin
      step(1, 1, 0, 0, '0);
      if (dma_valid) n++;
    end
    checks++;
    if (SC !== 2'b00) begin errors++; $display("FAIL b2b_timeout: got sc=%b exp 00 within 40 clks", SC); end
    checks++;
    if (n != 3 * BPL || gaps != 2 || r0 !== start + 16'(3 * BPL)) begin
      errors++; $display("FAIL b2b: got strobes=%0d gaps=%0d r0=%h exp 24 2 %h", n, gaps, r0, start + 16'(3 * BPL));
    end
  endtask

  task automatic test_enable_gating();
    int n = 0, last = 0;
    logic started = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      step(c % 4 == 0, started, 0, 0, '0);
      if (c % 4 == 0) started = 1;
      checks++;
      if ({dma_valid, dma_data, SC, r0} !== {e_valid, e_data, (e_busy ? 2'b10 : 2'b00), m_ptr}) begin
        errors++; $display("FAIL gated clk %0d: got v=%b d=%h sc=%b r0=%h exp v=%b d=%h r0=%h", c, dma_valid, dma_data, SC, r0, e_valid, e_data, m_ptr);
      end
      if (dma_valid) begin
        checks++;
        if (n > 0 && c - last != 8) begin errors++; $display("FAIL gated_gap: got %0d exp 8", c - last); end
        n++; last = c;
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL gated_timeout: got strobes=%0d exp 3", n); end
    #3 reset = 1;
    @(posedge clk); #1 reset = 0; model_reset();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step(1, 1, 0, 0, '0);
      if (dma_valid) n++;
    end
    checks++;
    if (n != 0 || SC !== 2'b00 || cpu_hold !== 1'b0 || r0 !== BASE) begin
      errors++; $display("FAIL midburst_reset: got strobes=%0d sc=%b h=%b r0=%h exp 0 00 0 %h", n, SC, cpu_hold, r0, BASE);
    end
  endtask

  task automatic test_random();
    logic it = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0) it = ~it;
      step($urandom_range(3) != 0, $urandom_range(2) != 0, it, $urandom_range(15) == 0, 16'($urandom));
      checks++;
      if ({dma_valid, dma_data, SC, cpu_hold, mem_rd, r0} !== {e_valid, e_data, (e_busy ? 2'b10 : 2'b00), e_busy, e_busy, m_ptr}
          || (e_busy && mem_addr !== m_ptr)) begin
        errors++; $display("FAIL random clk %0d: got v=%b d=%h sc=%b r0=%h a=%h exp v=%b d=%h busy=%b r0=%h", c, dma_valid, dma_data, SC, r0, mem_addr, e_valid, e_data, e_busy, m_ptr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_deferred_reload();
    test_write_priority();
    test_back_to_back();
    test_enable_gating();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
